neuron_sequencer: RTL and testbench
===================================

// Module: neuron_sequencer
// PURPOSE
// - Controls one inference pass of the cat recognizer datapath: pixel RegisterFile, weights_memory and NeuronCalculator.
// - Sits between fsm_apb/RegisterFile and the datapath.
// - In write mode, passes the APB address through to memory.
// - In compute mode, walks the pixel/weight addresses, drains the calculator pipeline and strobes finish_calc.
// - Latches the accumulator value and the cat bit, then reports done.
// PARAMETERS
// - Amba_Addr_Depth  13  memory address width
// - Num_Words        4096  pixel words per pass (addresses 1..Num_Words)
// - Pipe_Latency     3  cycles from last en_read to a valid acc_val
// - Acc_Width        64  accumulator width (signed)
// PORTS
// - clk              in   1                 single clock, all logic on posedge
// - rst              in   1                 synchronous, active-low reset
// - start            in   1                 control_reg level; 1 = compute, 0 = write mode
// - PADDR            in   Amba_Addr_Depth   APB address, used in write mode
// - acc_val          in   Acc_Width         signed accumulator from NeuronCalculator
// - cat_bit          in   1                 neuron_calculator_out
// - mem_address      out  Amba_Addr_Depth   address to RegisterFile/weights_memory
// - en_read          out  1                 read enable to memories and calculator
// - finish_calc      out  1                 one-cycle get_result strobe
// - busy             out  1                 1 in FETCH/DRAIN/CAPTURE/RESULT
// - done             out  1                 one-cycle pulse: pass complete
// - last_result      out  Acc_Width         acc_val captured at finish_calc
// - last_out         out  1                 cat bit of the last completed pass
// BEHAVIOUR
// - Reset (rst==0 at posedge): state=IDLE, addr_cnt=1, drain_cnt=0.
//   - All outputs are 0 except mem_address, which is also 0.
//   - Reset mid-pass aborts the pass at once; last_result and last_out are cleared.
// - All outputs are registered.
// - IDLE:
//   - mem_address<=PADDR; en_read=0; finish_calc=0.
//   - start==1 -> FETCH with addr_cnt=1.
// - FETCH:
//   - Each cycle: en_read<=1, mem_address<=addr_cnt, addr_cnt<=addr_cnt+1.
//   - Issues exactly Num_Words reads at addresses 1..Num_Words.
//   - After issuing address Num_Words -> DRAIN with drain_cnt=Pipe_Latency.
// - DRAIN:
//   - en_read<=0; mem_address holds; drain_cnt decrements.
//   - When drain_cnt reaches 1 -> CAPTURE.
// - CAPTURE (1 cycle): finish_calc<=1; last_result<=acc_val -> RESULT.
// - RESULT (1 cycle): finish_calc<=0; last_out<=cat_bit; done<=1 -> HOLD.
// - HOLD:
//   - done<=0; busy=0; stays while start==1, so there is no auto-restart.
//   - start==0 -> IDLE.
// - Latency: start sampled high at edge N.
//   - First en_read is high after edge N+1.
//   - done is high after edge N+Num_Words+Pipe_Latency+2.
// - Abort: start==0 in FETCH, DRAIN or CAPTURE -> IDLE next edge.
//   - en_read<=0, no finish_calc, no done.
//   - last_result and last_out keep their previous values.
// - Abort in RESULT: the pass completes; done still fires, then the block goes to IDLE.
// - PADDR is ignored outside IDLE; APB writes during a pass do not disturb mem_address.
// - addr_cnt is Amba_Addr_Depth+1 bits wide.
//   - Num_Words = 2**Amba_Addr_Depth-1 must not wrap.
//   - addr_cnt never exceeds Num_Words+1.
// - Pipe_Latency==0: DRAIN is skipped; FETCH goes directly to CAPTURE.
// CONFIGURATION
// - Macro CALC_CYCLE_CNT_EN defined:
//   - Adds output calc_cycles [31:0], cleared on reset and on the IDLE->FETCH transition.
//   - Increments every cycle while busy==1; holds its value in HOLD and IDLE; saturates at 32'hFFFFFFFF.
// - Macro undefined: the port and counter are absent; all other behaviour is identical.
// TESTING (Num_Words=4, Pipe_Latency=3, Acc_Width=64)
// - Reset: rst=0 for 2 cycles with start=1 -> all outputs 0, state IDLE, no en_read.
// - Write mode: start=0, PADDR=13'h0A5 -> mem_address==13'h0A5 one cycle later; en_read==0.
// - Full pass:
//   - Stimulus: start 0->1; acc_val=64'sd-17 and cat_bit=1 driven from the DRAIN exit.
//   - mem_address 1,2,3,4 on 4 consecutive en_read cycles, then 3 drain cycles.
//   - finish_calc for 1 cycle; last_result==-17; last_out==1; done 1 cycle.
//   - done 9 cycles after the start edge; calc_cycles==9 if CALC_CYCLE_CNT_EN.
// - Abort: drop start after the 2nd read -> IDLE next edge.
//   - No finish_calc and no done; last_result and last_out keep the prior pass values.
// - Hold/restart: keep start=1 after done -> no new en_read for 20 cycles.
//   - start 0->1 again -> a new pass begins at address 1.
// - Reset mid-DRAIN: rst=0 -> next edge busy=0, finish_calc never asserts, last_result==0.

Source files
------------

// File: rtl/neuron_sequencer.sv
// rtl/neuron_sequencer.sv - inference-pass sequencer for pixel/weight fetch, pipeline drain and result capture
// Optional cycle counter output calc_cycles enabled by defining CALC_CYCLE_CNT_EN.
module neuron_sequencer #(
  parameter int Amba_Addr_Depth = 13,
  parameter int Num_Words       = 4096,
  parameter int Pipe_Latency    = 3,
  parameter int Acc_Width       = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [Amba_Addr_Depth-1:0]  PADDR,
  input  logic signed [Acc_Width-1:0] acc_val,
  input  logic                        cat_bit,
  output logic [Amba_Addr_Depth-1:0]  mem_address,
  output logic                        en_read,
  output logic                        finish_calc,
  output logic                        busy,
  output logic                        done,
  output logic signed [Acc_Width-1:0] last_result,
`ifdef CALC_CYCLE_CNT_EN
  output logic [31:0]                 calc_cycles,
`endif
  output logic                        last_out
);

  localparam int CW = Amba_Addr_Depth + 1;
  localparam int DW = $clog2(Pipe_Latency + 2);
  localparam logic [CW-1:0] LAST_ADDR = CW'(Num_Words);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(Pipe_Latency);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DRAIN   = 3'd2,
    CAPTURE = 3'd3,
    RESULT  = 3'd4,
    HOLD    = 3'd5
  } state_t;

  state_t                        state, state_d;
  logic [CW-1:0]                 addr_cnt, addr_d;
  logic [DW-1:0]                 drain_cnt, drain_d;
  logic [Amba_Addr_Depth-1:0]    mem_d;
  logic                          en_d, fin_d, done_d, busy_d, out_d;
  logic signed [Acc_Width-1:0]   res_d;

  always_comb begin
    state_d = state;
    addr_d  = addr_cnt;
    drain_d = drain_cnt;
    mem_d   = mem_address;
    en_d    = 1'b0;
    fin_d   = 1'b0;
    done_d  = 1'b0;
    res_d   = last_result;
    out_d   = last_out;
    case (state)
      IDLE: begin
        mem_d  = PADDR;
        addr_d = CW'(1);
        if (start) state_d = FETCH;
      end
      FETCH: begin
        if (!start) begin
          state_d = IDLE;
        end else begin
          en_d   = 1'b1;
          mem_d  = addr_cnt[Amba_Addr_Depth-1:0];
          addr_d = addr_cnt + CW'(1);
          if (addr_cnt == LAST_ADDR) begin
            state_d = (Pipe_Latency == 0) ? CAPTURE : DRAIN;
            drain_d = DRAIN_INIT;
          end
        end
      end
      DRAIN: begin
        if (!start) begin
          state_d = IDLE;
        end else begin
          drain_d = drain_cnt - DW'(1);
          if (drain_cnt <= DW'(1)) state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!start) begin
          state_d = IDLE;
        end else begin
          fin_d   = 1'b1;
          res_d   = acc_val;
          state_d = RESULT;
        end
      end
      RESULT: begin
        // A pass that reached RESULT always reports, even if start just dropped.
        out_d   = cat_bit;
        done_d  = 1'b1;
        state_d = start ? HOLD : IDLE;
      end
      HOLD: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == FETCH) || (state_d == DRAIN) ||
             (state_d == CAPTURE) || (state_d == RESULT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      addr_cnt    <= CW'(1);
      drain_cnt   <= '0;
      mem_address <= '0;
      en_read     <= 1'b0;
      finish_calc <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      last_result <= '0;
      last_out    <= 1'b0;
    end else begin
      state       <= state_d;
      addr_cnt    <= addr_d;
      drain_cnt   <= drain_d;
      mem_address <= mem_d;
      en_read     <= en_d;
      finish_calc <= fin_d;
      busy        <= busy_d;
      done        <= done_d;
      last_result <= res_d;
      last_out    <= out_d;
    end
  end

`ifdef CALC_CYCLE_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      calc_cycles <= '0;
    end else if (state == IDLE && state_d == FETCH) begin
      calc_cycles <= '0;
    end else if (busy && calc_cycles != 32'hFFFF_FFFF) begin
      calc_cycles <= calc_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_neuron_sequencer.sv
// tb/tb_neuron_sequencer.sv - directed self-checking bench for neuron_sequencer
// Checks calc_cycles as well when CALC_CYCLE_CNT_EN is defined.
module tb_neuron_sequencer;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [12:0]        PADDR;
  logic signed [63:0] acc_val;
  logic               cat_bit;
  logic [12:0]        mem_address;
  logic               en_read, finish_calc, busy, done, last_out;
  logic signed [63:0] last_result;
`ifdef CALC_CYCLE_CNT_EN
  logic [31:0]        calc_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int seen_fin, seen_done, seen_en;

  neuron_sequencer #(
    .Amba_Addr_Depth(13), .Num_Words(4), .Pipe_Latency(3), .Acc_Width(64)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .PADDR(PADDR),
    .acc_val(acc_val), .cat_bit(cat_bit),
    .mem_address(mem_address), .en_read(en_read), .finish_calc(finish_calc),
    .busy(busy), .done(done), .last_result(last_result),
`ifdef CALC_CYCLE_CNT_EN
    .calc_cycles(calc_cycles),
`endif
    .last_out(last_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b1; PADDR = 13'h0; acc_val = 64'sd0; cat_bit = 1'b0;
    tick(); tick();
    chk("rst_mem", 64'(mem_address), 64'h0);
    chk("rst_en", 64'(en_read), 64'h0);
    chk("rst_fin", 64'(finish_calc), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_res", last_result, 64'h0);
    chk("rst_out", 64'(last_out), 64'h0);

    rst = 1'b1; start = 1'b0; PADDR = 13'h0A5;
    tick();
    chk("wr_mem", 64'(mem_address), 64'h0A5);
    chk("wr_en", 64'(en_read), 64'h0);

    // full pass: start edge N
    start = 1'b1;
    tick();
    chk("n0_en", 64'(en_read), 64'h0);
    chk("n0_busy", 64'(busy), 64'h1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("fetch_en", 64'(en_read), 64'h1);
      chk("fetch_addr", 64'(mem_address), 64'(i));
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drain_en", 64'(en_read), 64'h0);
      chk("drain_mem", 64'(mem_address), 64'h4);
      chk("drain_fin", 64'(finish_calc), 64'h0);
    end
    acc_val = -64'sd17; cat_bit = 1'b1;
    tick();
    chk("cap_fin", 64'(finish_calc), 64'h1);
    chk("cap_done", 64'(done), 64'h0);
    chk("cap_res", last_result, 64'hFFFF_FFFF_FFFF_FFEF);
    acc_val = 64'sd5;
    tick();
    chk("res_fin", 64'(finish_calc), 64'h0);
    chk("res_done", 64'(done), 64'h1);
    chk("res_out", 64'(last_out), 64'h1);
    chk("res_busy", 64'(busy), 64'h0);
`ifdef CALC_CYCLE_CNT_EN
    chk("calc_cycles", 64'(calc_cycles), 64'd9);
`endif
    cat_bit = 1'b0;

    // hold with start still high
    seen_en = 0; seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (en_read) seen_en++;
      if (done) seen_done++;
    end
    chk("hold_en", 64'(seen_en), 64'h0);
    chk("hold_done", 64'(seen_done), 64'h0);
    chk("hold_res", last_result, 64'hFFFF_FFFF_FFFF_FFEF);

    // restart, then abort after the second read
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    PADDR = 13'h1FF;
    tick();
    chk("rs_en", 64'(en_read), 64'h1);
    chk("rs_addr1", 64'(mem_address), 64'h1);
    tick();
    chk("rs_addr2", 64'(mem_address), 64'h2);
    start = 1'b0;
    tick();
    chk("ab_en", 64'(en_read), 64'h0);
    chk("ab_busy", 64'(busy), 64'h0);
    chk("ab_mem_hold", 64'(mem_address), 64'h2);
    seen_fin = 0; seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (finish_calc) seen_fin++;
      if (done) seen_done++;
    end
    chk("ab_fin", 64'(seen_fin), 64'h0);
    chk("ab_done", 64'(seen_done), 64'h0);
    chk("ab_res", last_result, 64'hFFFF_FFFF_FFFF_FFEF);
    chk("ab_out", 64'(last_out), 64'h1);
    chk("ab_idle_mem", 64'(mem_address), 64'h1FF);

    // reset in the middle of DRAIN
    start = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    chk("md_drain_en", 64'(en_read), 64'h0);
    chk("md_drain_busy", 64'(busy), 64'h1);
    rst = 1'b0;
    tick();
    chk("md_busy", 64'(busy), 64'h0);
    chk("md_res", last_result, 64'h0);
    chk("md_out", 64'(last_out), 64'h0);
    chk("md_mem", 64'(mem_address), 64'h0);
    rst = 1'b1; start = 1'b0;
    seen_fin = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (finish_calc) seen_fin++;
    end
    chk("md_fin", 64'(seen_fin), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
